wb_regfile: RTL and testbench
=============================

# wb_regfile

Write-back stage and general-purpose register file of the five-stage MIPS pipeline. It consumes the W-stage bundle presented by the M-to-W pipeline register, selects the write-back datum, and commits it to a 32×32 register file. It serves the two combinational read ports of the decode stage and keeps a registered commit record plus a retired-write counter for trace and verification.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index, 32 registers.
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- MemtoReg_W2  in  1  1 selects ReadData_W2 as the write-back datum, 0 selects RegData_W2
- RegWrite_W2  in  1  write enable for the W-stage instruction
- ReadData_W2  in  32  load data from the memory stage
- RegData_W2  in  32  ALU/link result
- WriteReg_W2  in  5  destination register index
- PC_W2  in  32  PC of the W-stage instruction (trace only)
- A1_D, A2_D  in  5 each  decode-stage read addresses
- RD1_D, RD2_D  out  32 each  decode-stage read data, combinational
- WD_W  out  32  selected write-back datum, combinational; feeds the E/M forwarding muxes
- CommitValid  out  1  registered; 1 for exactly one cycle after each committed write
- CommitPC, CommitData  out  32 each  registered PC and datum of the last committed write
- CommitReg  out  5  registered destination index of the last committed write
- RetireCnt  out  32  number of committed writes since reset

## Operation
- WD_W = MemtoReg_W2 ? ReadData_W2 : RegData_W2.
- Commit condition: reset high, RegWrite_W2 = 1, and WriteReg_W2 ≠ 0.
- On a rising edge with the commit condition true, register WriteReg_W2 receives WD_W.
- $0 reads as 0 at all times. Writes to $0 are discarded and do not count as commits.
- Reads are combinational: RDn_D = (An_D == 0) ? 0 : reg[An_D], subject to the bypass described under Configuration.
- Commit record: on each edge, CommitValid <= commit condition. When the commit condition is true, CommitPC, CommitReg and CommitData load PC_W2, WriteReg_W2 and WD_W. Otherwise they hold their values.
- RetireCnt increments by 1 on each commit. It wraps from 0xFFFF_FFFF to 0 with no flag.
- A W-stage bubble (all-zero bundle, RegWrite_W2 = 0) changes nothing except driving CommitValid low.

## Timing
- Reset asserted: all 31 registers, CommitValid, CommitPC, CommitReg, CommitData and RetireCnt go to 0 immediately, without waiting for a clock edge.
- While reset is asserted, RD1_D and RD2_D read 0. WD_W stays combinational from its inputs.
- Reset asserted on the same cycle as a write: the write is lost and the counter does not increment.
- Reset release is sampled at clock edges. The first edge after release may commit.
- Write latency: the new value is visible at the read ports from the edge that commits it. Commit record and RetireCnt update on that same edge.
- Same-cycle read of the register being written: the result is defined by the bypass macro.
- Both read ports addressing the same register, or A1_D == A2_D == WriteReg_W2: both ports return the same value.

## Configuration
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: if the commit condition is true and An_D == WriteReg_W2, then RDn_D = WD_W in the same cycle, giving write-before-read semantics. This removes the D/W forwarding path in the hazard unit.
- Undefined: RDn_D returns the pre-write register value until the commit edge. The hazard unit must then forward W→D.
- All other behaviour is identical with and without the macro.

## Structure
- Shared package mips_pkg holds:
  - REG_W = 5, DATA_W = 32, NUM_REGS = 32
  - ZERO_REG = 5'd0
  - a commit_rec_t struct {valid, pc, reg, data}, reused by the trace monitor
- One natural sub-module: gpr_array. It holds the 31-entry storage, one write port, and two combinational read ports with the $0 rule.
- The top level holds the write-back mux, commit logic, bypass, commit record and counter.

## Test plan
- Reset, then read all 32 addresses on both ports → every read returns 0. RetireCnt = 0 and CommitValid = 0.
- Write $5 with RegData_W2 = 0x1234_5678, MemtoReg_W2 = 0, PC_W2 = 0x3000 → after the edge:
  - RD1_D for A1_D = 5 returns 0x1234_5678
  - CommitValid pulses for one cycle
  - CommitReg = 5, CommitPC = 0x3000
  - RetireCnt = 1
- Load path: MemtoReg_W2 = 1, ReadData_W2 = 0xDEAD_BEEF, RegData_W2 = 0x1 → $7 = 0xDEAD_BEEF and WD_W = 0xDEAD_BEEF.
- Write 0xFFFF_FFFF to $0 → RD of $0 stays 0, RetireCnt unchanged, CommitValid stays 0.
- $9 holds 0x11. Write 0x22 to $9 while A2_D = 9, before the edge:
  - with WB_REGFILE_BYPASS_EN: RD2_D = 0x22
  - without it: RD2_D = 0x11
- Assert reset between clock edges while $3 = 0xAA → $3, RetireCnt and Commit* read 0 before the next edge. Preload RetireCnt to 0xFFFF_FFFF via 2^32−1 forced commits (or a force in the bench), then commit once → RetireCnt = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and widths: register-file geometry and the
// commit record consumed by the trace monitor.
package mips_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // One retired register write. The destination field is called wreg
    // because reg is a reserved word.
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] data;
    } commit_rec_t;

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage bundle, decode read ports and commit trace of the write-back stage.
// master = pipeline side driving the W-stage bundle and read addresses,
// slave  = wb_regfile.
interface wb_regfile_if;
    import mips_pkg::*;

    logic              MemtoReg_W2;
    logic              RegWrite_W2;
    logic [DATA_W-1:0] ReadData_W2;
    logic [DATA_W-1:0] RegData_W2;
    logic [REG_W-1:0]  WriteReg_W2;
    logic [DATA_W-1:0] PC_W2;
    logic [REG_W-1:0]  A1_D;
    logic [REG_W-1:0]  A2_D;
    logic [DATA_W-1:0] RD1_D;
    logic [DATA_W-1:0] RD2_D;
    logic [DATA_W-1:0] WD_W;
    logic              CommitValid;
    logic [DATA_W-1:0] CommitPC;
    logic [DATA_W-1:0] CommitData;
    logic [REG_W-1:0]  CommitReg;
    logic [DATA_W-1:0] RetireCnt;

    modport master (
        output MemtoReg_W2, RegWrite_W2, ReadData_W2, RegData_W2, WriteReg_W2, PC_W2,
        output A1_D, A2_D,
        input  RD1_D, RD2_D, WD_W,
        input  CommitValid, CommitPC, CommitData, CommitReg, RetireCnt
    );

    modport slave (
        input  MemtoReg_W2, RegWrite_W2, ReadData_W2, RegData_W2, WriteReg_W2, PC_W2,
        input  A1_D, A2_D,
        output RD1_D, RD2_D, WD_W,
        output CommitValid, CommitPC, CommitData, CommitReg, RetireCnt
    );

endinterface

// File: rtl/wb_regfile_gpr_array.sv
// gpr_array: 31 general-purpose registers ($1..$31), one synchronous write
// port and two combinational read ports; $0 is not stored and reads as 0.
module gpr_array
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [REG_W-1:0]  i_ra1,
    input  logic [REG_W-1:0]  i_ra2,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2
);

    logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];

    // Storage: cleared asynchronously by reset, written on the rising edge.
    // NOTE: this array is reset on purpose -- every register must read 0
    // immediately on reset, so it maps to flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != ZERO_REG)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rd1 = (i_ra1 == ZERO_REG) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == ZERO_REG) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage plus general-purpose register file.
// Selects the write-back datum, commits it to gpr_array, and keeps a
// registered commit record and a wrapping retired-write counter.
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle write-before-read on the
// decode read ports (removes the W->D forwarding path in the hazard unit).
module wb_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    wb_regfile_if.slave bus
);

    logic [DATA_W-1:0] w_wd;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd1_raw;
    logic [DATA_W-1:0] w_rd2_raw;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    commit_rec_t       r_commit;
    logic [DATA_W-1:0] r_retire_cnt;

    assign w_wd = bus.MemtoReg_W2 ? bus.ReadData_W2 : bus.RegData_W2;

    // A write to $0 is discarded and never counts as a commit.
    assign w_commit = reset && bus.RegWrite_W2 && (bus.WriteReg_W2 != ZERO_REG);

    gpr_array u_gpr (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_commit),
        .i_waddr (bus.WriteReg_W2),
        .i_wdata (w_wd),
        .i_ra1   (bus.A1_D),
        .i_ra2   (bus.A2_D),
        .o_rd1   (w_rd1_raw),
        .o_rd2   (w_rd2_raw)
    );

    // Read-port bypass: optionally forward the datum being committed this cycle.
    // NOTE: outputs get a default first so no path through this block infers a latch.
    always_comb begin
        w_rd1 = w_rd1_raw;
        w_rd2 = w_rd2_raw;
`ifdef WB_REGFILE_BYPASS_EN
        if (w_commit && (bus.A1_D == bus.WriteReg_W2)) w_rd1 = w_wd;
        if (w_commit && (bus.A2_D == bus.WriteReg_W2)) w_rd2 = w_wd;
`endif
    end

    // Commit record: valid pulses per commit, payload holds between commits.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_commit <= '0;
        end else begin
            r_commit.valid <= w_commit;
            if (w_commit) begin
                r_commit.pc   <= bus.PC_W2;
                r_commit.wreg <= bus.WriteReg_W2;
                r_commit.data <= w_wd;
            end
        end
    end

    // Retired-write counter, wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign bus.WD_W        = w_wd;
    assign bus.RD1_D       = w_rd1;
    assign bus.RD2_D       = w_rd2;
    assign bus.CommitValid = r_commit.valid;
    assign bus.CommitPC    = r_commit.pc;
    assign bus.CommitReg   = r_commit.wreg;
    assign bus.CommitData  = r_commit.data;
    assign bus.RetireCnt   = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. Inputs change 1 ns after a
// rising edge; outputs are sampled mid-cycle, away from the edge.
module tb_wb_regfile;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    wb_regfile_if bus ();

    wb_regfile dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mtr, input logic we, input logic [31:0] rdata,
                         input logic [31:0] regdata, input logic [4:0] wreg,
                         input logic [31:0] pc);
        bus.MemtoReg_W2 = mtr;
        bus.RegWrite_W2 = we;
        bus.ReadData_W2 = rdata;
        bus.RegData_W2  = regdata;
        bus.WriteReg_W2 = wreg;
        bus.PC_W2       = pc;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bubble();
        bus.A1_D = 5'd0;
        bus.A2_D = 5'd0;
        #2;

        // Under reset every address reads 0 on both ports.
        for (int a = 0; a < 32; a++) begin
            bus.A1_D = a[4:0];
            bus.A2_D = 5'(31 - a);
            #1;
            check($sformatf("reset_rd1_a%0d", a), bus.RD1_D, 32'h0);
            check($sformatf("reset_rd2_a%0d", a), bus.RD2_D, 32'h0);
        end
        check("reset_retirecnt", bus.RetireCnt, 32'h0);
        check("reset_commitvalid", {31'h0, bus.CommitValid}, 32'h0);

        // Release reset between edges.
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU write to $5.
        drive(1'b0, 1'b1, 32'h0, 32'h1234_5678, 5'd5, 32'h0000_3000);
        tick();
        bubble();
        bus.A1_D = 5'd5;
        #1;
        check("wr5_rd1", bus.RD1_D, 32'h1234_5678);
        check("wr5_commitvalid", {31'h0, bus.CommitValid}, 32'h1);
        check("wr5_commitreg", {27'h0, bus.CommitReg}, 32'd5);
        check("wr5_commitpc", bus.CommitPC, 32'h0000_3000);
        check("wr5_commitdata", bus.CommitData, 32'h1234_5678);
        check("wr5_retirecnt", bus.RetireCnt, 32'd1);
        tick();
        check("bubble_commitvalid", {31'h0, bus.CommitValid}, 32'h0);
        check("bubble_commitreg_hold", {27'h0, bus.CommitReg}, 32'd5);
        check("bubble_retirecnt_hold", bus.RetireCnt, 32'd1);

        // Load path into $7.
        drive(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 5'd7, 32'h0000_3004);
        #1;
        check("load_wd_w", bus.WD_W, 32'hDEAD_BEEF);
        tick();
        bubble();
        bus.A1_D = 5'd7;
        #1;
        check("load_rd1", bus.RD1_D, 32'hDEAD_BEEF);
        check("load_commitdata", bus.CommitData, 32'hDEAD_BEEF);
        check("load_retirecnt", bus.RetireCnt, 32'd2);

        // Write to $0 is discarded.
        drive(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd0, 32'h0000_3008);
        tick();
        bubble();
        bus.A1_D = 5'd0;
        #1;
        check("zero_rd1", bus.RD1_D, 32'h0);
        check("zero_retirecnt", bus.RetireCnt, 32'd2);
        check("zero_commitvalid", {31'h0, bus.CommitValid}, 32'h0);
        check("zero_commitreg_hold", {27'h0, bus.CommitReg}, 32'd7);

        // Both ports on the same register.
        bus.A1_D = 5'd7;
        bus.A2_D = 5'd7;
        #1;
        check("same_rd1", bus.RD1_D, 32'hDEAD_BEEF);
        check("same_rd2", bus.RD2_D, 32'hDEAD_BEEF);

        // $9 = 0x11, then same-cycle read while writing 0x22.
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0011, 5'd9, 32'h0000_300C);
        tick();
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0022, 5'd9, 32'h0000_3010);
        bus.A1_D = 5'd9;
        bus.A2_D = 5'd9;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        check("rw9_rd2_pre_edge", bus.RD2_D, 32'h0000_0022);
        check("rw9_rd1_pre_edge", bus.RD1_D, 32'h0000_0022);
`else
        check("rw9_rd2_pre_edge", bus.RD2_D, 32'h0000_0011);
        check("rw9_rd1_pre_edge", bus.RD1_D, 32'h0000_0011);
`endif
        tick();
        bubble();
        #1;
        check("rw9_rd2_post_edge", bus.RD2_D, 32'h0000_0022);
        check("rw9_retirecnt", bus.RetireCnt, 32'd4);

        // $3 = 0xAA, then async reset mid-cycle with a write pending.
        drive(1'b0, 1'b1, 32'h0, 32'h0000_00AA, 5'd3, 32'h0000_3014);
        tick();
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0055, 5'd4, 32'h0000_3018);
        bus.A1_D = 5'd3;
        bus.A2_D = 5'd3;
        #1;
        check("pre_rst_rd1", bus.RD1_D, 32'h0000_00AA);
        check("pre_rst_retirecnt", bus.RetireCnt, 32'd5);
        reset = 1'b0;
        #1;
        check("rst_rd1", bus.RD1_D, 32'h0);
        check("rst_retirecnt", bus.RetireCnt, 32'h0);
        check("rst_commitvalid", {31'h0, bus.CommitValid}, 32'h0);
        check("rst_commitpc", bus.CommitPC, 32'h0);
        check("rst_commitdata", bus.CommitData, 32'h0);
        check("rst_commitreg", {27'h0, bus.CommitReg}, 32'h0);
        check("rst_wd_w_comb", bus.WD_W, 32'h0000_0055);
        tick();
        bus.A1_D = 5'd4;
        #1;
        check("rst_write_lost", bus.RD1_D, 32'h0);
        check("rst_no_count", bus.RetireCnt, 32'h0);

        // First edge after release commits.
        @(negedge clk);
        reset = 1'b1;
        tick();
        bubble();
        #1;
        check("post_rst_rd1", bus.RD1_D, 32'h0000_0055);
        check("post_rst_retirecnt", bus.RetireCnt, 32'd1);

        // Counter wrap: preload to all-ones, then commit once.
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        #1;
        check("wrap_preload", bus.RetireCnt, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 32'h0, 32'h0000_0777, 5'd31, 32'h0000_301C);
        tick();
        bubble();
        bus.A1_D = 5'd31;
        #1;
        check("wrap_retirecnt", bus.RetireCnt, 32'h0);
        check("wrap_rd31", bus.RD1_D, 32'h0000_0777);
        check("wrap_commitvalid", {31'h0, bus.CommitValid}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
